cdc_xfer_arbiter: RTL and testbench
===================================

CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the crossing channel (2..8).
REQ-002 Parameter DATA_W, default 8: payload width per requester.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on the returning ack (>=2).
REQ-004 Parameter TIMEOUT_CYC, default 255: handshake cycles before timeout flag (>=1).
REQ-005 clk  input  1  block clock; all logic on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  NUM_REQ  per-requester transfer request.
REQ-008 req_data  input  NUM_REQ*DATA_W  payloads; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  output  NUM_REQ  one-hot acceptance strobe; payload taken when valid&ready.
REQ-010 xfer_req  output  1  registered 4-phase request level to remote domain.
REQ-011 xfer_data  output  DATA_W  registered payload, stable while xfer_req high or ack pending.
REQ-012 xfer_ack_async  input  1  remote-domain ack level, asynchronous to clk.
REQ-013 grant_id  output  $clog2(NUM_REQ)  index of requester owning current transfer.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on handshake completion.
REQ-016 err_timeout  output  1  sticky timeout flag.
REQ-017 err_clr  input  1  synchronous clear of err_timeout.

Function
REQ-018 FSM states: IDLE, REQ_HI, REQ_LO.
REQ-019 IDLE: if any req_valid, winner = first valid at or after rr_ptr (wrapping); req_ready[winner]=1 combinationally same cycle; capture req_data slice into xfer_data, winner into grant_id; next state REQ_HI.
REQ-020 req_ready SHALL be all-zero in REQ_HI and REQ_LO; new requests wait, never dropped.
REQ-021 REQ_HI: xfer_req=1 (asserted the cycle after acceptance); on ack_sync=1, xfer_req<=0, go REQ_LO.
REQ-022 REQ_LO: xfer_req=0; on ack_sync=0, pulse done, rr_ptr<=grant_id+1 modulo NUM_REQ, go IDLE.
REQ-023 ack_sync = xfer_ack_async after SYNC_STAGES flops in clk; FSM SHALL use only ack_sync.
REQ-024 IDLE with ack_sync=1 (stale ack): no acceptance until ack_sync=0.
REQ-025 Round-robin: a continuously valid requester SHALL be granted within NUM_REQ transfers.
REQ-026 Timeout counter: cleared on entering REQ_HI and REQ_LO, increments each cycle there, saturating; on reaching TIMEOUT_CYC set err_timeout; FSM continues waiting (no abort).
REQ-027 err_clr and new timeout same cycle: set wins.
REQ-028 xfer_data and grant_id SHALL hold until next acceptance.

Reset
REQ-029 Reset SHALL force: state IDLE, xfer_req 0, xfer_data 0, grant_id 0, rr_ptr 0, done 0, err_timeout 0, counter 0, all sync flops 0.
REQ-030 Reset mid-handshake SHALL drop xfer_req immediately (async) and abandon transfer; no done.

Structure
REQ-031 Package cdc_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-032 Sub-module sync_ff_chain (SYNC_STAGES flops, async reset to 0) SHALL synchronize xfer_ack_async.

Verification
REQ-033 Single request: req_valid=4'b0100, data 8'hA5; remote acks 3 cycles after xfer_req -> req_ready=4'b0100 cycle 0, xfer_req high cycle 1, xfer_data=8'hA5, grant_id=2, one done pulse, busy low after.
REQ-034 All four valid continuously, rr_ptr=0 -> grants in order 0,1,2,3,0; exactly one req_ready bit per acceptance.
REQ-035 Remote never acks, TIMEOUT_CYC=16 -> err_timeout set 16 cycles into REQ_HI, xfer_req stays high; err_clr clears it; later ack completes transfer normally.
REQ-036 Reset asserted while in REQ_LO -> xfer_req 0, busy 0, no done, rr_ptr 0; post-reset request granted to lowest valid index.
REQ-037 Ack held high on entry to IDLE with req_valid=4'b0001 -> req_ready stays 0 until ack_sync falls, then accepted.
REQ-038 Ack glitch shorter than one clk period -> no state change beyond synchronizer, no spurious done.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and default parameter values for the clock-crossing transfer arbiter.
// The handshake FSM state encoding lives here so the top and bench agree on names.
package cdc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReqHi = 2'd1,
        StReqLo = 2'd2
    } state_e;

    localparam int unsigned DefNumReq     = 4;
    localparam int unsigned DefDataW      = 8;
    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefTimeoutCyc = 255;

endpackage

// File: rtl/cdc_xfer_arbiter_if.sv
// Bundle of requester-side and remote-side handshake signals of the transfer arbiter.
// The slave modport is the arbiter's view; master is the view of whoever drives it.
interface cdc_xfer_arbiter_if #(
    parameter int unsigned NUM_REQ = cdc_pkg::DefNumReq,
    parameter int unsigned DATA_W  = cdc_pkg::DefDataW
) ();
    localparam int unsigned GrantW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      xfer_req;
    logic [DATA_W-1:0]         xfer_data;
    logic                      xfer_ack_async;
    logic [GrantW-1:0]         grant_id;
    logic                      busy;
    logic                      done;
    logic                      err_timeout;
    logic                      err_clr;

    modport slave (
        input  req_valid, req_data, xfer_ack_async, err_clr,
        output req_ready, xfer_req, xfer_data, grant_id, busy, done, err_timeout
    );

    modport master (
        output req_valid, req_data, xfer_ack_async, err_clr,
        input  req_ready, xfer_req, xfer_data, grant_id, busy, done, err_timeout
    );

endinterface

// File: rtl/sync_ff_chain.sv
// Multi-flop level synchronizer for a single bit arriving from another clock domain.
// All stages reset asynchronously to zero.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter that hands one requester's payload at a time across a clock
// boundary with a 4-phase req/ack handshake, plus a sticky handshake timeout flag.
module cdc_xfer_arbiter
    import cdc_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DefNumReq,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input logic               clk,
    input logic               reset,
    cdc_xfer_arbiter_if.slave io_bus
);
    localparam int unsigned     GrantW = $clog2(NUM_REQ);
    localparam int unsigned     CntW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

    state_e            r_state;
    logic              r_xfer_req;
    logic              r_done;
    logic              r_err_timeout;
    logic [DATA_W-1:0] r_xfer_data;
    logic [GrantW-1:0] r_grant_id;
    logic [GrantW-1:0] r_rr_ptr;
    logic [CntW-1:0]   r_cnt;

    logic              w_ack_sync;
    logic              w_any;
    logic              w_accept;
    logic              w_cnt_sat;
    logic              w_cnt_hit;
    logic [GrantW-1:0] w_idx;
    logic [GrantW-1:0] w_winner;
    logic [GrantW-1:0] w_rr_next;

    sync_ff_chain #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .reset(reset),
        .i_d  (io_bus.xfer_ack_async),
        .o_q  (w_ack_sync)
    );

    // Scan requesters starting at the round-robin pointer, wrapping around.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = GrantW'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any && io_bus.req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // A stale ack still high from the remote side blocks new acceptances.
    assign w_accept  = (r_state == StIdle) && !w_ack_sync && w_any;
    assign w_rr_next = (r_grant_id == GrantW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_cnt_sat = (r_cnt == CntMax);
    assign w_cnt_hit = (r_cnt == CntMax - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_xfer_req    <= 1'b0;
            r_xfer_data   <= '0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_done <= 1'b0;
            if (io_bus.err_clr) begin
                r_err_timeout <= 1'b0;
            end
            // Later assignments to r_err_timeout below take precedence over the clear.
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_xfer_data <= io_bus.req_data[32'(w_winner) * DATA_W +: DATA_W];
                        r_grant_id  <= w_winner;
                        r_xfer_req  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= StReqHi;
                    end
                end
                StReqHi: begin
                    if (w_ack_sync) begin
                        r_xfer_req <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= StReqLo;
                    end else begin
                        if (!w_cnt_sat) r_cnt <= r_cnt + 1'b1;
                        if (w_cnt_hit) r_err_timeout <= 1'b1;
                    end
                end
                StReqLo: begin
                    if (!w_ack_sync) begin
                        r_done   <= 1'b1;
                        r_rr_ptr <= w_rr_next;
                        r_state  <= StIdle;
                    end else begin
                        if (!w_cnt_sat) r_cnt <= r_cnt + 1'b1;
                        if (w_cnt_hit) r_err_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_xfer_req <= 1'b0;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.req_ready   = w_accept ? (NUM_REQ'(1) << w_winner) : '0;
    assign io_bus.xfer_req    = r_xfer_req;
    assign io_bus.xfer_data   = r_xfer_data;
    assign io_bus.grant_id    = r_grant_id;
    assign io_bus.busy        = (r_state != StIdle);
    assign io_bus.done        = r_done;
    assign io_bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Bench for cdc_xfer_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized phase scored against a transaction-level round-robin model.
module tb_cdc_xfer_arbiter;

    localparam int NReq = 4;
    localparam int DW   = 8;

    logic clk;
    logic reset;

    cdc_xfer_arbiter_if #(.NUM_REQ(NReq), .DATA_W(DW)) bus ();

    cdc_xfer_arbiter #(
        .NUM_REQ    (NReq),
        .DATA_W     (DW),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          ack_dly;
        int          exp_grant;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    // Randomized-phase state
    int   items[NReq][6];
    int   cnt_i[NReq];
    int   head[NReq];
    int   exp_q[$];
    int   model_rr, outstanding, accepts, dones, total, cyc, eg, e, rst_st, rdly;
    logic rnd_done, prev_xreq;
    logic [3:0]  rv;
    logic [31:0] rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NReq; k++) begin
            if (v[(ptr + k) % NReq]) return (ptr + k) % NReq;
        end
        return -1;
    endfunction

    // Called one time unit after a rising edge; returns one unit after the acceptance edge.
    task automatic start_xfer(input logic [3:0] v, input logic [31:0] d, input int eg_i,
                              input logic [7:0] ed, input string tag);
        bus.req_valid = v;
        bus.req_data  = d;
        #1;
        chk({tag, " ready"}, 32'(bus.req_ready), 32'(1) << eg_i);
        tick();
        chk({tag, " ready held low"}, 32'(bus.req_ready), 0);
        bus.req_valid = '0;
        chk({tag, " xfer_req"}, 32'(bus.xfer_req), 1);
        chk({tag, " busy"}, 32'(bus.busy), 1);
        chk({tag, " grant"}, 32'(bus.grant_id), 32'(eg_i));
        chk({tag, " data"}, 32'(bus.xfer_data), 32'(ed));
    endtask

    task automatic finish_xfer(input int ack_dly, input int eg_i, input logic [7:0] ed,
                               input string tag);
        int n;
        int nd;
        repeat (ack_dly) tick();
        bus.xfer_ack_async = 1'b1;
        n = 0;
        while (bus.xfer_req === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " req dropped"}, 32'(bus.xfer_req), 0);
        bus.xfer_ack_async = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done === 1'b1) nd++;
        end
        chk({tag, " done pulses"}, 32'(nd), 1);
        chk({tag, " busy after"}, 32'(bus.busy), 0);
        chk({tag, " grant held"}, 32'(bus.grant_id), 32'(eg_i));
        chk({tag, " data held"}, 32'(bus.xfer_data), 32'(ed));
    endtask

    initial begin
        vecs[0] = '{4'b0100, 32'h44A5_2211, 3, 2, 8'hA5};
        vecs[1] = '{4'b1111, 32'hD3C2_B1A0, 0, 3, 8'hD3};
        vecs[2] = '{4'b1111, 32'h0F1E_2D3C, 1, 0, 8'h3C};
        vecs[3] = '{4'b1111, 32'h5566_7788, 2, 1, 8'h77};
        vecs[4] = '{4'b1111, 32'h99AA_BBCC, 5, 2, 8'hAA};
        vecs[5] = '{4'b1111, 32'h1234_5678, 0, 3, 8'h12};
        vecs[6] = '{4'b1111, 32'hDEAD_BEEF, 1, 0, 8'hEF};
        vecs[7] = '{4'b0101, 32'hCAFE_F00D, 2, 2, 8'hFE};
        vecs[8] = '{4'b0011, 32'h0000_A55A, 0, 0, 8'h5A};
        vecs[9] = '{4'b1000, 32'h7700_0000, 4, 3, 8'h77};

        reset              = 1'b1;
        bus.req_valid      = '0;
        bus.req_data       = '0;
        bus.xfer_ack_async = 1'b0;
        bus.err_clr        = 1'b0;
        #12;
        chk("reset xfer_req", 32'(bus.xfer_req), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset err", 32'(bus.err_timeout), 0);
        chk("reset grant", 32'(bus.grant_id), 0);
        chk("reset data", 32'(bus.xfer_data), 0);
        reset = 1'b0;
        tick();
        chk("idle ready", 32'(bus.req_ready), 0);

        for (int i = 0; i < 10; i++) begin
            start_xfer(vecs[i].valid, vecs[i].data, vecs[i].exp_grant, vecs[i].exp_data,
                       $sformatf("vec%0d", i));
            finish_xfer(vecs[i].ack_dly, vecs[i].exp_grant, vecs[i].exp_data,
                        $sformatf("vec%0d", i));
        end
        chk("vec err", 32'(bus.err_timeout), 0);

        // Timeout: remote silent, flag rises 16 cycles into the request phase.
        start_xfer(4'b0001, 32'h0000_0042, 0, 8'h42, "tmo");
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 15) begin
                chk("tmo err before", 32'(bus.err_timeout), 0);
                bus.err_clr = 1'b1;
            end
            if (n == 16) begin
                chk("tmo set wins over clr", 32'(bus.err_timeout), 1);
                chk("tmo req held", 32'(bus.xfer_req), 1);
                bus.err_clr = 1'b0;
            end
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("tmo cleared", 32'(bus.err_timeout), 0);
        repeat (3) tick();
        chk("tmo stays clear", 32'(bus.err_timeout), 0);
        chk("tmo req still high", 32'(bus.xfer_req), 1);
        finish_xfer(0, 0, 8'h42, "tmo");
        chk("tmo err after", 32'(bus.err_timeout), 0);

        // Reset while the return-to-zero phase is pending.
        start_xfer(4'b0010, 32'h0000_6600, 1, 8'h66, "rst");
        bus.xfer_ack_async = 1'b1;
        for (int n = 0; n < 40 && bus.xfer_req === 1'b1; n++) tick();
        chk("rst in req_lo", 32'(bus.xfer_req), 0);
        #2 reset = 1'b1;
        #1;
        chk("rst xfer_req", 32'(bus.xfer_req), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst grant", 32'(bus.grant_id), 0);
        bus.xfer_ack_async = 1'b0;
        tick();
        chk("rst no done", 32'(bus.done), 0);
        #3 reset = 1'b0;
        tick();
        chk("rst no done after", 32'(bus.done), 0);
        chk("rst busy after", 32'(bus.busy), 0);
        start_xfer(4'b1001, 32'h8800_0033, 0, 8'h33, "postrst");
        finish_xfer(1, 0, 8'h33, "postrst");

        // Stale ack high while idle blocks acceptance until its synchronized copy falls.
        bus.xfer_ack_async = 1'b1;
        repeat (3) tick();
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_00C3;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("stale ready low", 32'(bus.req_ready), 0);
            chk("stale busy", 32'(bus.busy), 0);
            tick();
        end
        bus.xfer_ack_async = 1'b0;
        #1;
        chk("stale ready low 2", 32'(bus.req_ready), 0);
        tick();
        chk("stale ready low 3", 32'(bus.req_ready), 0);
        tick();
        start_xfer(4'b0001, 32'h0000_00C3, 0, 8'hC3, "stale");
        finish_xfer(0, 0, 8'hC3, "stale");

        // Sub-period ack glitch during the request phase must be ignored.
        start_xfer(4'b0100, 32'h00E7_0000, 2, 8'hE7, "glitch");
        #2 bus.xfer_ack_async = 1'b1;
        #3 bus.xfer_ack_async = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("glitch req held", 32'(bus.xfer_req), 1);
            chk("glitch no done", 32'(bus.done), 0);
        end
        finish_xfer(2, 2, 8'hE7, "glitch");

        // Randomized phase: every requester has a backlog, valid held until taken.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        total = 0;
        for (int i = 0; i < NReq; i++) begin
            cnt_i[i] = $urandom_range(3, 6);
            head[i]  = 0;
            total += cnt_i[i];
            for (int j = 0; j < 6; j++) items[i][j] = $urandom_range(0, 255);
        end
        model_rr    = 0;
        outstanding = 0;
        accepts     = 0;
        dones       = 0;
        cyc         = 0;
        rnd_done    = 1'b0;
        prev_xreq   = 1'b0;
        rst_st      = 0;
        rdly        = 0;
        fork
            begin
                while (!rnd_done) begin
                    tick();
                    cyc++;
                    if (bus.done === 1'b1) begin
                        chk("rnd done with transfer", 32'(outstanding), 1);
                        outstanding = 0;
                        dones++;
                    end
                    if (bus.xfer_req === 1'b1 && !prev_xreq) begin
                        if (exp_q.size() == 0) begin
                            chk("rnd unexpected xfer", 32'(bus.xfer_req), 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rnd grant_id", 32'(bus.grant_id), 32'(e / 256));
                            chk("rnd xfer_data", 32'(bus.xfer_data), 32'(e % 256));
                        end
                    end
                    prev_xreq = bus.xfer_req;
                    for (int i = 0; i < NReq; i++) begin
                        rv[i] = (head[i] < cnt_i[i]);
                        rd[i*8 +: 8] = rv[i] ? 8'(items[i][head[i]]) : 8'($urandom_range(0, 255));
                    end
                    bus.req_valid = rv;
                    bus.req_data  = rd;
                    #1;
                    if (bus.req_ready !== 4'b0000) begin
                        eg = rr_pick(rv, model_rr);
                        chk("rnd ready", 32'(bus.req_ready), 32'(1) << eg);
                        chk("rnd idle at accept", 32'(outstanding), 0);
                        if (eg >= 0) begin
                            exp_q.push_back(eg * 256 + items[eg][head[eg]]);
                            head[eg]++;
                            model_rr = (eg + 1) % NReq;
                        end
                        outstanding = 1;
                        accepts++;
                    end
                    if (dones == total) begin
                        rnd_done = 1'b1;
                    end else if (cyc >= 4000) begin
                        chk("rnd drain budget", 32'(dones), 32'(total));
                        rnd_done = 1'b1;
                    end
                end
            end
            begin
                while (!rnd_done) begin
                    tick();
                    case (rst_st)
                        0: if (bus.xfer_req === 1'b1) begin
                            rdly   = $urandom_range(0, 4);
                            rst_st = 1;
                        end
                        1: if (rdly == 0) begin
                            bus.xfer_ack_async = 1'b1;
                            rst_st = 2;
                        end else rdly--;
                        2: if (bus.xfer_req === 1'b0) begin
                            rdly   = $urandom_range(0, 4);
                            rst_st = 3;
                        end
                        default: if (rdly == 0) begin
                            bus.xfer_ack_async = 1'b0;
                            rst_st = 0;
                        end else rdly--;
                    endcase
                end
            end
        join
        bus.req_valid = '0;
        chk("rnd accepts", 32'(accepts), 32'(total));
        chk("rnd queue empty", 32'(exp_q.size()), 0);
        chk("rnd err", 32'(bus.err_timeout), 0);
        chk("rnd busy end", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
